// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO peripheral for the rv32soc CPU bus.
//   Per-pin direction, atomic SET/CLR, synchronised inputs, per-pin edge interrupts.
// Ports:
//   clk, reset                  rising-edge clock, async active-high reset
//   bus_valid/addr/wstrb/wdata  CPU request (held until bus_ready), wstrb=0 is a read
//   bus_ready, bus_rdata        one-cycle completion pulse, registered read data
//   gpio_in                     asynchronous pin inputs
//   gpio_out, gpio_oe           output data and output enable registers
//   irq                         level interrupt, |(IRQ_STATUS & IRQ_EN)
module gpio_ctrl #(
  parameter int NR_GPIOS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bus_valid,
  input  logic [4:0]          bus_addr,
  input  logic [3:0]          bus_wstrb,
  input  logic [31:0]         bus_wdata,
  output logic                bus_ready,
  output logic [31:0]         bus_rdata,
  input  logic [NR_GPIOS-1:0] gpio_in,
  output logic [NR_GPIOS-1:0] gpio_out,
  output logic [NR_GPIOS-1:0] gpio_oe,
  output logic                irq
);

  localparam int W = NR_GPIOS;

  logic                          ready_q, ready_d;
  logic [31:0]                   rdata_q, rdata_d;
  logic [W-1:0]                  out_q, out_d;
  logic [W-1:0]                  dir_q, dir_d;
  logic [W-1:0]                  en_q, en_d;
  logic [W-1:0]                  mode_q, mode_d;
  logic [W-1:0]                  status_q, status_d;
  logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
  logic [W-1:0]                  prev_q, prev_d;

  logic          start, wr, rd;
  logic [31:0]   wmask, wm, rmux;
  logic [W-1:0]  sync_in, rise, fall, set_ev;

  function automatic logic [31:0] zext(input logic [W-1:0] v);
    logic [31:0] r;
    r      = '0;
    r[W-1:0] = v;
    return r;
  endfunction

  // A request is new only while bus_ready is low; the second cycle of a held
  // bus_valid is the completion cycle of the same access.
  assign start   = bus_valid & ~ready_q;
  assign wr      = start & (|bus_wstrb);
  assign rd      = start & ~(|bus_wstrb);
  assign wmask   = {{8{bus_wstrb[3]}}, {8{bus_wstrb[2]}}, {8{bus_wstrb[1]}}, {8{bus_wstrb[0]}}};
  assign wm      = bus_wdata & wmask;

  assign sync_in = sync_q[SYNC_STAGES-1];
  assign rise    = sync_in & ~prev_q;
  assign fall    = ~sync_in & prev_q;
  assign set_ev  = ((rise & ~mode_q) | (fall & mode_q)) & en_q;

  logic unused_ok;
  assign unused_ok = ^{bus_addr[1:0], wm};

  always_comb begin
    rmux = '0;
    case (bus_addr[4:2])
      3'd0:    rmux = zext(out_q);
      3'd1:    rmux = zext(dir_q);
      3'd2:    rmux = zext(sync_in);
      3'd5:    rmux = zext(en_q);
      3'd6:    rmux = zext(mode_q);
      3'd7:    rmux = zext(status_q);
      default: rmux = '0;
    endcase
  end

  always_comb begin
    ready_d  = start;
    rdata_d  = rd ? rmux : '0;
    out_d    = out_q;
    dir_d    = dir_q;
    en_d     = en_q;
    mode_d   = mode_q;
    status_d = status_q;
    prev_d   = sync_in;
    sync_d   = sync_q;
    sync_d[0] = gpio_in;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];

    if (wr) begin
      case (bus_addr[4:2])
        3'd0:    out_d    = (out_q & ~wmask[W-1:0]) | wm[W-1:0];
        3'd1:    dir_d    = (dir_q & ~wmask[W-1:0]) | wm[W-1:0];
        3'd3:    out_d    = out_q | wm[W-1:0];
        3'd4:    out_d    = out_q & ~wm[W-1:0];
        3'd5:    en_d     = (en_q & ~wmask[W-1:0]) | wm[W-1:0];
        3'd6:    mode_d   = (mode_q & ~wmask[W-1:0]) | wm[W-1:0];
        3'd7:    status_d = status_q & ~wm[W-1:0];
        default: ;
      endcase
    end
    // Applied after the W1C so a coincident edge keeps the bit set.
    status_d = status_d | set_ev;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      out_q    <= '0;
      dir_q    <= '0;
      en_q     <= '0;
      mode_q   <= '0;
      status_q <= '0;
      sync_q   <= '0;
      prev_q   <= '0;
    end else begin
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      out_q    <= out_d;
      dir_q    <= dir_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      status_q <= status_d;
      sync_q   <= sync_d;
      prev_q   <= prev_d;
    end
  end

  assign bus_ready = ready_q;
  assign bus_rdata = rdata_q;
  assign gpio_out  = out_q;
  assign gpio_oe   = dir_q;
  assign irq       = |(status_q & en_q);

endmodule
